cell_font_selector: RTL and testbench

CELL_FONT_SELECTOR -- requirements
Module: cell_font_selector

---
 rtl/cell_font_pkg.sv | 93 +++++++++
 rtl/cell_font_selector_blink_timer.sv | 41 ++++
 rtl/cell_font_selector.sv | 178 +++++++++++++++++
 tb/tb_cell_font_selector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cell_font_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_font_pkg
//  Description : Font ROM codes, keypad screen layout and the placement
//                overlap helper shared by the cell font selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package cell_font_pkg;

  localparam int FONT_W = 5;

  // Glyph indices 0..15 are the hex digits themselves
  localparam logic [FONT_W-1:0] c_plus   = 5'd16;
  localparam logic [FONT_W-1:0] c_minus  = 5'd17;
  localparam logic [FONT_W-1:0] c_times  = 5'd18;
  localparam logic [FONT_W-1:0] c_div    = 5'd19;
  localparam logic [FONT_W-1:0] c_root   = 5'd20;
  localparam logic [FONT_W-1:0] c_bksp   = 5'd21;
  localparam logic [FONT_W-1:0] c_equals = 5'd22;
  localparam logic [FONT_W-1:0] c_ac     = 5'd23;
  localparam logic [FONT_W-1:0] c_empty  = 5'd24;
  localparam logic [FONT_W-1:0] c_dot    = 5'd25;
  localparam logic [FONT_W-1:0] c_cursor = 5'd26;

  // Keypad is a 5x4 grid: rows 8/10/12/14, columns 4/10/16/22/28.
  //   7 8 9 / AC
  //   4 5 6 x BKSP
  //   1 2 3 - ROOT
  //   0 . = + (empty)
  function automatic logic [FONT_W-1:0] keypad_code(input logic [15:0] col,
                                                     input logic [15:0] row);
    logic [1:0] r;
    logic [2:0] c;
    logic       hit_r;
    logic       hit_c;
    keypad_code = c_empty;
    r     = 2'd0;
    c     = 3'd0;
    hit_r = 1'b1;
    hit_c = 1'b1;
    case (row)
      16'd8:   r = 2'd0;
      16'd10:  r = 2'd1;
      16'd12:  r = 2'd2;
      16'd14:  r = 2'd3;
      default: hit_r = 1'b0;
    endcase
    case (col)
      16'd4:   c = 3'd0;
      16'd10:  c = 3'd1;
      16'd16:  c = 3'd2;
      16'd22:  c = 3'd3;
      16'd28:  c = 3'd4;
      default: hit_c = 1'b0;
    endcase
    if (hit_r && hit_c) begin
      case ({r, c})
        5'd0:    keypad_code = 5'd7;
        5'd1:    keypad_code = 5'd8;
        5'd2:    keypad_code = 5'd9;
        5'd3:    keypad_code = c_div;
        5'd4:    keypad_code = c_ac;
        5'd8:    keypad_code = 5'd4;
        5'd9:    keypad_code = 5'd5;
        5'd10:   keypad_code = 5'd6;
        5'd11:   keypad_code = c_times;
        5'd12:   keypad_code = c_bksp;
        5'd16:   keypad_code = 5'd1;
        5'd17:   keypad_code = 5'd2;
        5'd18:   keypad_code = 5'd3;
        5'd19:   keypad_code = c_minus;
        5'd20:   keypad_code = c_root;
        5'd24:   keypad_code = 5'd0;
        5'd25:   keypad_code = c_dot;
        5'd26:   keypad_code = c_equals;
        5'd27:   keypad_code = c_plus;
        default: keypad_code = c_empty;
      endcase
    end
  endfunction

  // True when any digit cell lands on a mapped keypad cell
  function automatic bit layout_overlaps(input int num_digits, input int start_col,
                                         input int pitch, input int row);
    layout_overlaps = 1'b0;
    for (int i = 0; i < num_digits; i++) begin
      if (keypad_code(16'(start_col + i * pitch), 16'(row)) != c_empty)
        layout_overlaps = 1'b1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_font_selector_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : blink_timer
//  Description : Counts frames and toggles the cursor blink phase every
//                BLINK_FRAMES frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int c_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLINK_FRAMES - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               r_phase;

  // Frame counter wraps at the half-period and flips the phase as it wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (frame_start) begin
      if (r_count == c_last) begin
        r_count <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign blink_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/cell_font_selector.sv
`default_nettype none
// ============================================================================
//  Module      : cell_font_selector
//  Description : Maps character-cell coordinates to a font ROM index for the
//                hex digit row and the on-screen keypad, with frame-stable
//                digit snapshot, leading-zero blanking and a blinking cursor.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_font_selector
  import cell_font_pkg::*;
#(
  parameter int NUM_DIGITS   = 10,
  parameter int CX_W         = 6,
  parameter int CY_W         = 6,
  parameter int DISPLAY_ROW  = 5,
  parameter int START_COL    = 2,
  parameter int COL_PITCH    = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  input  logic [CX_W-1:0]               cuenta_x_alta,
  input  logic [CY_W-1:0]               cuenta_y_alta,
  input  logic [4*NUM_DIGITS-1:0]       numeros,
  input  logic [$clog2(NUM_DIGITS)-1:0] cursor_pos,
  input  logic                          cursor_en,
  input  logic                          lz_blank_en,
  output logic [4:0]                    font_select,
  output logic                          font_valid,
  output logic                          blink_phase
);

  localparam int c_idx_w = $clog2(NUM_DIGITS);

  if (layout_overlaps(NUM_DIGITS, START_COL, COL_PITCH, DISPLAY_ROW)) begin : g_layout_overlap
    $error("cell_font_selector: digit cells overlap keypad cells");
  end
  if (BLINK_FRAMES < 1) begin : g_blink_range
    $error("cell_font_selector: BLINK_FRAMES must be at least 1");
  end

  logic [4*NUM_DIGITS-1:0] r_shadow_num;
  logic [c_idx_w-1:0]      r_shadow_cpos;
  logic                    r_shadow_cen;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [NUM_DIGITS-1:0]   w_mask;
  logic                    w_zero_run;
  logic                    w_blink;

  logic                    w_hit;
  logic [c_idx_w-1:0]      w_idx;
  logic [3:0]              w_nibble;
  logic                    w_blank;

  logic                    r_s1_hit;
  logic [c_idx_w-1:0]      r_s1_idx;
  logic [FONT_W-1:0]       r_s1_kp;
  logic                    r_s1_valid;
  logic [3:0]              r_s1_nibble;
  logic                    r_s1_blank;
  logic                    r_s1_cur_on;
  logic [c_idx_w-1:0]      r_s1_cur_pos;

  logic [FONT_W-1:0]       w_font;
  logic [FONT_W-1:0]       r_font;
  logic                    r_valid;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .blink_phase (w_blink)
  );

  // Leading-zero run from the most-significant digit down; digit 0 always shows
  always_comb begin
    w_mask     = '0;
    w_zero_run = lz_blank_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run = w_zero_run && (numeros[4*i +: 4] == 4'd0);
      w_mask[i]  = w_zero_run;
    end
  end

  // Per-frame snapshot so a value change mid-frame cannot tear the display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_num  <= '0;
      r_shadow_cpos <= '0;
      r_shadow_cen  <= 1'b0;
      r_mask        <= '0;
    end else if (frame_start) begin
      r_shadow_num  <= numeros;
      r_shadow_cpos <= cursor_pos;
      r_shadow_cen  <= cursor_en;
      r_mask        <= w_mask;
    end
  end

  // Locate the digit cell (if any) under the current coordinates
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_nibble = 4'd0;
    w_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((int'(cuenta_x_alta) == START_COL + (NUM_DIGITS - 1 - i) * COL_PITCH) &&
          (int'(cuenta_y_alta) == DISPLAY_ROW)) begin
        w_hit    = 1'b1;
        w_idx    = c_idx_w'(i);
        w_nibble = r_shadow_num[4*i +: 4];
        w_blank  = r_mask[i];
      end
    end
  end

  // Stage 1: capture cell decode together with the shadow state seen this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hit     <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_kp      <= c_empty;
      r_s1_valid   <= 1'b0;
      r_s1_nibble  <= 4'd0;
      r_s1_blank   <= 1'b0;
      r_s1_cur_on  <= 1'b0;
      r_s1_cur_pos <= '0;
    end else begin
      r_s1_hit     <= w_hit;
      r_s1_idx     <= w_idx;
      r_s1_kp      <= keypad_code(16'(cuenta_x_alta), 16'(cuenta_y_alta));
      r_s1_valid   <= pix_valid;
      r_s1_nibble  <= w_nibble;
      r_s1_blank   <= w_blank;
      r_s1_cur_on  <= r_shadow_cen && w_blink;
      r_s1_cur_pos <= r_shadow_cpos;
    end
  end

  // Glyph priority on digit cells: cursor, then blank, then hex value.
  // An out-of-range cursor position never matches a real digit index.
  always_comb begin
    w_font = c_empty;
    if (r_s1_valid) begin
      if (r_s1_hit) begin
        if (r_s1_cur_on && (r_s1_idx == r_s1_cur_pos))
          w_font = c_cursor;
        else if (r_s1_blank)
          w_font = c_empty;
        else
          w_font = {1'b0, r_s1_nibble};
      end else begin
        w_font = r_s1_kp;
      end
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_font  <= c_empty;
      r_valid <= 1'b0;
    end else begin
      r_font  <= w_font;
      r_valid <= r_s1_valid;
    end
  end

  assign font_select = r_font;
  assign font_valid  = r_valid;
  assign blink_phase = w_blink;

endmodule
`default_nettype wire

// File: tb/tb_cell_font_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_font_selector
//  Description : Scoreboard bench for cell_font_selector: the driver queues
//                the expected glyph per stimulus cycle, the monitor pops and
//                compares two edges later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_font_selector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  cx = '0;
  logic [5:0]  cy = '0;
  logic [39:0] numeros = '0;
  logic [3:0]  cursor_pos = '0;
  logic        cursor_en = 1'b0;
  logic        lz_blank_en = 1'b0;
  logic [4:0]  font_select;
  logic        font_valid;
  logic        blink_phase;

  cell_font_selector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid     (pix_valid),
    .frame_start   (frame_start),
    .cuenta_x_alta (cx),
    .cuenta_y_alta (cy),
    .numeros       (numeros),
    .cursor_pos    (cursor_pos),
    .cursor_en     (cursor_en),
    .lz_blank_en   (lz_blank_en),
    .font_select   (font_select),
    .font_valid    (font_valid),
    .blink_phase   (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    logic [4:0] font;
    logic       vld;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   edges = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_ids = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  // Monitor: compare whatever the DUT presents against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].tgt == edges) begin
        e = exp_q.pop_front();
        check($sformatf("pix%0d_font", e.id), int'(font_select), int'(e.font));
        check($sformatf("pix%0d_valid", e.id), int'(font_valid), int'(e.vld));
      end else if (exp_q.size() > 0 && exp_q[0].tgt < edges) begin
        e = exp_q.pop_front();
        check($sformatf("pix%0d_late", e.id), edges, e.tgt);
      end else if (font_valid !== 1'b0 || font_select !== 5'd24) begin
        n_checks++;
        $display("FAIL spurious_output: got font=%0d valid=%0d, required 24/0",
                 font_select, font_valid);
      end
    end
  end

  // One stimulus cycle; the expected output is due two edges later
  task automatic step(input int x, input int y, input bit v, input bit fs,
                      input logic [4:0] ef);
    @(negedge clk);
    cx          = 6'(x);
    cy          = 6'(y);
    pix_valid   = v;
    frame_start = fs;
    exp_q.push_back('{tgt: edges + 2, font: (v ? ef : 5'd24), vld: v, id: n_ids});
    n_ids++;
  endtask

  task automatic pix(input int x, input int y, input logic [4:0] ef);
    step(x, y, 1'b1, 1'b0, ef);
  endtask

  task automatic idle();
    step(0, 0, 1'b0, 1'b0, 5'd24);
  endtask

  task automatic fstart();
    step(0, 0, 1'b0, 1'b1, 5'd24);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_font", int'(font_select), 24);
    check("reset_valid", int'(font_valid), 0);
    check("reset_blink", int'(blink_phase), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and basic digit values
    numeros = 40'h0123456789;
    lz_blank_en = 1'b0;
    fstart();
    pix(2, 5, 5'd0);
    pix(38, 5, 5'd9);
    pix(26, 5, 5'd6);
    idle();

    // Leading-zero blanking
    numeros = 40'h00000000A5;
    lz_blank_en = 1'b1;
    fstart();
    for (int c = 2; c <= 30; c += 4) pix(c, 5, 5'd24);
    pix(34, 5, 5'd10);
    pix(38, 5, 5'd5);
    numeros = 40'h0;
    fstart();
    for (int c = 2; c <= 34; c += 4) pix(c, 5, 5'd24);
    pix(38, 5, 5'd0);

    // No tearing: new value only after the frame_start edge
    numeros = 40'h0123456789;
    lz_blank_en = 1'b0;
    pix(38, 5, 5'd0);
    pix(34, 5, 5'd24);
    pix(2, 5, 5'd24);
    step(38, 5, 1'b1, 1'b1, 5'd0);
    pix(38, 5, 5'd9);
    pix(34, 5, 5'd8);
    pix(2, 5, 5'd0);

    // Keypad and empty cells
    pix(10, 8, 5'd8);
    pix(28, 8, 5'd23);
    pix(22, 14, 5'd16);
    pix(16, 12, 5'd3);
    pix(4, 10, 5'd4);
    pix(0, 0, 5'd24);
    pix(4, 9, 5'd24);
    step(2, 5, 1'b0, 1'b0, 5'd24);

    // Asynchronous reset mid-stream
    pix(38, 5, 5'd9);
    pix(34, 5, 5'd8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_font", int'(font_select), 24);
    check("async_reset_valid", int'(font_valid), 0);
    check("async_reset_blink", int'(blink_phase), 0);
    @(negedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    frame_start = 1'b0;
    rst_n = 1'b1;
    idle();
    idle();
    pix(38, 5, 5'd0);
    pix(2, 5, 5'd0);

    // Cursor blink
    numeros = 40'h0123456789;
    lz_blank_en = 1'b0;
    cursor_en = 1'b1;
    cursor_pos = 4'd3;
    repeat (29) fstart();
    idle();
    check("blink_after_29", int'(blink_phase), 0);
    pix(26, 5, 5'd6);
    fstart();
    idle();
    check("blink_after_30", int'(blink_phase), 1);
    pix(26, 5, 5'd26);
    pix(22, 5, 5'd5);
    cursor_pos = 4'd12;
    fstart();
    idle();
    check("blink_oob_phase", int'(blink_phase), 1);
    pix(26, 5, 5'd6);
    cursor_pos = 4'd3;
    repeat (29) fstart();
    idle();
    check("blink_after_60", int'(blink_phase), 0);
    pix(26, 5, 5'd6);
    idle();

    // Drain outstanding expectations
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
